cva6_axi_txn_monitor: RTL and testbench

//  Passive monitor on the CVA6 AXI4 master port, between the core and the SoC crossbar; never drives the bus.

---
 rtl/cva6_axi_txn_monitor.sv | 177 +++++++++++++++++
 tb/tb_cva6_axi_txn_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cva6_axi_txn_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cva6_axi_txn_monitor
// Description : Passive monitor on the CVA6 AXI4 master port. Tracks
//               outstanding write/read transactions, counts error responses,
//               flags counter overflow/underflow and runs a no-progress
//               watchdog. Sticky flags drive a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module cva6_axi_txn_monitor #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned ERR_CNT_W       = 16,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 axi_aw_valid_i,
    input  logic                 axi_aw_ready_i,
    input  logic                 axi_b_valid_i,
    input  logic                 axi_b_ready_i,
    input  logic [1:0]           axi_b_resp_i,
    input  logic                 axi_ar_valid_i,
    input  logic                 axi_ar_ready_i,
    input  logic                 axi_r_valid_i,
    input  logic                 axi_r_ready_i,
    input  logic                 axi_r_last_i,
    input  logic [1:0]           axi_r_resp_i,
    output logic [CNT_W-1:0]     wr_outstanding_o,
    output logic [CNT_W-1:0]     rd_outstanding_o,
    output logic [ERR_CNT_W-1:0] err_resp_cnt_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 timeout_o,
    output logic                 irq_o
);

    localparam int unsigned      c_WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_MAX     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_TIMEOUT = 2'd2;

    logic [1:0]           r_state;
    logic [c_WD_W-1:0]    r_wd;
    logic [CNT_W-1:0]     r_wr_cnt, r_rd_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_ovf, r_unf, r_to, r_irq;

    logic                 w_aw_hs, w_b_hs, w_ar_hs, w_r_hs, w_rd_dec, w_progress, w_busy;
    logic [CNT_W-1:0]     w_wr_next, w_rd_next;
    logic                 w_wr_ovf, w_wr_unf, w_rd_ovf, w_rd_unf;
    logic [ERR_CNT_W:0]   w_err_sum;
    logic [ERR_CNT_W-1:0] w_err_next;
    logic [1:0]           w_state_next;
    logic [c_WD_W-1:0]    w_wd_next;
    logic                 w_to_evt, w_ovf_next, w_unf_next, w_to_next;
    logic                 w_unused;

    // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign w_unused   = ^{axi_b_resp_i[0], axi_r_resp_i[0]};

    assign w_aw_hs    = axi_aw_valid_i & axi_aw_ready_i;
    assign w_b_hs     = axi_b_valid_i  & axi_b_ready_i;
    assign w_ar_hs    = axi_ar_valid_i & axi_ar_ready_i;
    assign w_r_hs     = axi_r_valid_i  & axi_r_ready_i;
    assign w_rd_dec   = w_r_hs & axi_r_last_i;
    assign w_progress = w_b_hs | w_r_hs;
    assign w_busy     = (w_wr_next != '0) || (w_rd_next != '0);

    // Write outstanding counter: saturate at both ends and report the violation.
    always_comb begin
        w_wr_next = r_wr_cnt;
        w_wr_ovf  = 1'b0;
        w_wr_unf  = 1'b0;
        if (w_aw_hs && !w_b_hs) begin
            if (r_wr_cnt == c_MAX) w_wr_ovf  = 1'b1;
            else                   w_wr_next = r_wr_cnt + CNT_W'(1);
        end else if (!w_aw_hs && w_b_hs) begin
            if (r_wr_cnt == '0)    w_wr_unf  = 1'b1;
            else                   w_wr_next = r_wr_cnt - CNT_W'(1);
        end
    end

    // Read outstanding counter: only the last R beat retires a read.
    always_comb begin
        w_rd_next = r_rd_cnt;
        w_rd_ovf  = 1'b0;
        w_rd_unf  = 1'b0;
        if (w_ar_hs && !w_rd_dec) begin
            if (r_rd_cnt == c_MAX) w_rd_ovf  = 1'b1;
            else                   w_rd_next = r_rd_cnt + CNT_W'(1);
        end else if (!w_ar_hs && w_rd_dec) begin
            if (r_rd_cnt == '0)    w_rd_unf  = 1'b1;
            else                   w_rd_next = r_rd_cnt - CNT_W'(1);
        end
    end

    // Error counter: clear first, then add this cycle's errors with saturation.
    always_comb begin
        w_err_sum  = {1'b0, (clear_i ? '0 : r_err_cnt)}
                   + (ERR_CNT_W + 1)'(w_b_hs & axi_b_resp_i[1])
                   + (ERR_CNT_W + 1)'(w_r_hs & axi_r_resp_i[1]);
        w_err_next = w_err_sum[ERR_CNT_W] ? '1 : w_err_sum[ERR_CNT_W-1:0];
    end

    // Watchdog FSM: counts consecutive no-progress cycles while transactions are open.
    always_comb begin
        w_state_next = r_state;
        w_wd_next    = '0;
        w_to_evt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_busy) w_state_next = S_BUSY;
            end
            S_BUSY: begin
                if (!w_busy) begin
                    w_state_next = S_IDLE;
                end else if ((r_wd == c_WD_LAST) && !w_progress) begin
                    w_state_next = S_TIMEOUT;
                    w_to_evt     = 1'b1;
                end else if (!w_progress && !clear_i) begin
                    w_wd_next = r_wd + c_WD_W'(1);
                end
            end
            S_TIMEOUT: begin
                if (clear_i) w_state_next = w_busy ? S_BUSY : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sticky flags: a clear drops old state, events in the same cycle still land.
    always_comb begin
        w_ovf_next = (clear_i ? 1'b0 : r_ovf) | w_wr_ovf | w_rd_ovf;
        w_unf_next = (clear_i ? 1'b0 : r_unf) | w_wr_unf | w_rd_unf;
        w_to_next  = (clear_i ? 1'b0 : r_to)  | w_to_evt;
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_wd      <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_to      <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wd      <= w_wd_next;
            r_wr_cnt  <= w_wr_next;
            r_rd_cnt  <= w_rd_next;
            r_err_cnt <= w_err_next;
            r_ovf     <= w_ovf_next;
            r_unf     <= w_unf_next;
            r_to      <= w_to_next;
            r_irq     <= w_ovf_next | w_unf_next | w_to_next;
        end
    end

    assign wr_outstanding_o = r_wr_cnt;
    assign rd_outstanding_o = r_rd_cnt;
    assign err_resp_cnt_o   = r_err_cnt;
    assign overflow_o       = r_ovf;
    assign underflow_o      = r_unf;
    assign timeout_o        = r_to;
    assign irq_o            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cva6_axi_txn_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cva6_axi_txn_monitor
// Description : Directed-vector scoreboard bench for cva6_axi_txn_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cva6_axi_txn_monitor;

    localparam int unsigned MAXO = 8;
    localparam int unsigned TOC  = 16;
    localparam int unsigned EW   = 4;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          rst, clear;
    logic          aw_valid, aw_ready, b_valid, b_ready, ar_valid, ar_ready;
    logic          r_valid, r_ready, r_last;
    logic [1:0]    b_resp, r_resp;
    logic [CW-1:0] wr_out, rd_out;
    logic [EW-1:0] err_out;
    logic          ovf_out, unf_out, to_out, irq_out;

    typedef struct packed {
        logic [CW-1:0] wr;
        logic [CW-1:0] rd;
        logic [EW-1:0] err;
        logic          ovf;
        logic          unf;
        logic          to;
        logic          irq;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    cva6_axi_txn_monitor #(
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (TOC),
        .ERR_CNT_W      (EW)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .clear_i          (clear),
        .axi_aw_valid_i   (aw_valid),
        .axi_aw_ready_i   (aw_ready),
        .axi_b_valid_i    (b_valid),
        .axi_b_ready_i    (b_ready),
        .axi_b_resp_i     (b_resp),
        .axi_ar_valid_i   (ar_valid),
        .axi_ar_ready_i   (ar_ready),
        .axi_r_valid_i    (r_valid),
        .axi_r_ready_i    (r_ready),
        .axi_r_last_i     (r_last),
        .axi_r_resp_i     (r_resp),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out),
        .err_resp_cnt_o   (err_out),
        .overflow_o       (ovf_out),
        .underflow_o      (unf_out),
        .timeout_o        (to_out),
        .irq_o            (irq_out)
    );

    // Apply one cycle of stimulus and queue the outputs expected after its edge.
    task automatic cyc(input logic aw, input logic b, input logic [1:0] bresp,
                       input logic ar, input logic r, input logic rl, input logic [1:0] rresp,
                       input logic clr, input int wr, input int rd, input int err,
                       input logic ovf, input logic unf, input logic to, input string nm);
        exp_t e;
        aw_valid = 1'b1;  aw_ready = aw;
        b_valid  = b;     b_ready  = 1'b1;  b_resp = bresp;
        ar_valid = ar;    ar_ready = 1'b1;
        r_valid  = 1'b1;  r_ready  = r;     r_last = rl;  r_resp = rresp;
        clear    = clr;
        @(posedge clk);
        e.wr  = CW'(wr);
        e.rd  = CW'(rd);
        e.err = EW'(err);
        e.ovf = ovf;
        e.unf = unf;
        e.to  = to;
        e.irq = ovf | unf | to;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
    endtask

    task automatic idle(input int wr, input int rd, input int err,
                        input logic ovf, input logic unf, input logic to, input string nm);
        cyc(0, 0, 2'b00, 0, 0, 0, 2'b00, 0, wr, rd, err, ovf, unf, to, nm);
    endtask

    // Scoreboard monitor: compare DUT outputs against the queued expectation mid-cycle.
    initial begin
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {wr_out, rd_out, err_out, ovf_out, unf_out, to_out, irq_out};
                n_vec++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got wr=%0d rd=%0d err=%0d ovf=%b unf=%b to=%b irq=%b, expected wr=%0d rd=%0d err=%0d ovf=%b unf=%b to=%b irq=%b",
                             nm, act.wr, act.rd, act.err, act.ovf, act.unf, act.to, act.irq,
                             e.wr, e.rd, e.err, e.ovf, e.unf, e.to, e.irq);
                end
            end
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1; clear = 1'b0;
        aw_valid = 0; aw_ready = 0; b_valid = 0; b_ready = 0; b_resp = 0;
        ar_valid = 0; ar_ready = 0; r_valid = 0; r_ready = 0; r_last = 0; r_resp = 0;
        repeat (2) @(posedge clk);
        #1;
        idle(0, 0, 0, 0, 0, 0, "reset");
        rst = 1'b0;

        // Three writes issued then retired in order.
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, "t1_aw1");
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2, 0, 0, 0, 0, 0, "t1_aw2");
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 3, 0, 0, 0, 0, 0, "t1_aw3");
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 2, 0, 0, 0, 0, 0, "t1_b1");
        cyc(0, 1, 2'b01, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, "t1_b2_exokay");
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t1_b3");

        // One read with a 4-beat burst, second beat SLVERR.
        cyc(0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, "t2_ar");
        cyc(0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, "t2_beat1");
        cyc(0, 0, 2'b00, 0, 1, 0, 2'b10, 0, 0, 1, 1, 0, 0, 0, "t2_beat2_slverr");
        cyc(0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, "t2_beat3");
        cyc(0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0, "t2_last");

        // Simultaneous inc/dec, fill to the limit, then overflow.
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, "t3_aw1");
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2, 0, 1, 0, 0, 0, "t3_aw2");
        cyc(1, 1, 2'b00, 0, 0, 0, 2'b00, 0, 2, 0, 1, 0, 0, 0, "t3_aw_b_same");
        for (int i = 3; i <= 8; i++)
            cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, i, 0, 1, 0, 0, 0, "t3_fill");
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 8, 0, 1, 1, 0, 0, "t3_overflow");
        for (int i = 7; i >= 0; i--)
            cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, i, 0, 1, 1, 0, 0, "t3_drain");
        cyc(0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, "t3_clear");

        // Underflow and clear racing a new underflow.
        cyc(0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t4_r_nolast_at0");
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, "t4_underflow");
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, "t4_clear_with_b");
        cyc(0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, "t4_clear");

        // Lone write at cycle 0 with no response: timeout visible in cycle 17.
        cyc(1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, "t5_aw");
        for (int i = 1; i <= 15; i++)
            idle(1, 0, 0, 0, 0, 0, "t5_wait");
        idle(1, 0, 0, 0, 0, 1, "t5_timeout");
        idle(1, 0, 0, 0, 0, 1, "t5_sticky");
        cyc(0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, "t5_clear");
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t5_drain");

        // Same start but an R beat at cycle 10 keeps the watchdog quiet.
        cyc(1, 0, 2'b00, 1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, "t5b_aw_ar");
        for (int i = 1; i <= 9; i++)
            idle(1, 1, 0, 0, 0, 0, "t5b_wait_a");
        cyc(0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, "t5b_beat");
        for (int i = 11; i <= 19; i++)
            idle(1, 1, 0, 0, 0, 0, "t5b_wait_b");
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, "t5b_b");
        cyc(0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t5b_rlast");

        // Error counter saturation (4 bits), two errors per cycle.
        for (int i = 1; i <= 7; i++)
            cyc(1, 1, 2'b11, 1, 1, 1, 2'b10, 0, 0, 0, 2 * i, 0, 0, 0, "t6_ramp");
        cyc(1, 1, 2'b11, 1, 1, 1, 2'b10, 0, 0, 0, 15, 0, 0, 0, "t6_saturate");
        cyc(1, 1, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 15, 0, 0, 0, "t6_hold");
        cyc(1, 1, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0, "t6_clear_event_wins");

        // Reset mid-transaction, then a late response for the lost write.
        cyc(1, 0, 2'b00, 1, 0, 0, 2'b00, 0, 1, 1, 1, 0, 0, 0, "t7_aw_ar");
        rst = 1'b1;
        idle(0, 0, 0, 0, 0, 0, "t7_reset");
        rst = 1'b0;
        cyc(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, "t7_late_b");
        idle(0, 0, 0, 0, 1, 0, "t7_sticky");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
